// File: rtl/bcd_display_stage_if.sv
// Display-stage bus: CPU-side load/value in, registered BCD digits and
// active-low seven-segment patterns out.
interface bcd_display_stage_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] value;
  logic             load;
  logic             busy;
  logic             done;
  logic [3:0]       hundreds;
  logic [3:0]       tens;
  logic [3:0]       ones;
  logic             overflow;
  logic [6:0]       seg2;
  logic [6:0]       seg1;
  logic [6:0]       seg0;

  modport master (
    output value, load,
    input  busy, done, hundreds, tens, ones, overflow, seg2, seg1, seg0
  );

  modport slave (
    input  value, load,
    output busy, done, hundreds, tens, ones, overflow, seg2, seg1, seg0
  );
endinterface

// File: rtl/bcd_display_stage.sv
// Binary-to-BCD display stage: iterative double-dabble (one bit per cycle)
// feeding registered active-low seven-segment outputs with optional blanking.
module bcd_display_stage #(
  parameter int unsigned WIDTH         = 16,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input logic                  clk,
  input logic                  n_reset,
  bcd_display_stage_if.slave   bus
);

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegDash  = 7'b0111111;
  localparam logic [6:0] SegZero  = 7'b1000000;
  localparam logic [6:0] SegLeadReset = BLANK_LEADING ? SegBlank : SegZero;

  typedef enum logic [1:0] {StIdle, StConv, StFinish} stateT;

  stateT            stateQ, stateD;
  logic [WIDTH-1:0] shiftQ, shiftD;
  logic [19:0]      accQ, accD;
  logic [4:0]       cntQ, cntD;
  logic             doneQ, doneD;
  logic [3:0]       hundredsQ, hundredsD;
  logic [3:0]       tensQ, tensD;
  logic [3:0]       onesQ, onesD;
  logic             overflowQ, overflowD;
  logic [6:0]       seg2Q, seg2D;
  logic [6:0]       seg1Q, seg1D;
  logic [6:0]       seg0Q, seg0D;
  logic [19:0]      accAdj;

  function automatic logic [6:0] segOf(input logic [3:0] digit);
    logic [6:0] seg;
    unique case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SegBlank;
    endcase
    return seg;
  endfunction

  // Double-dabble correction: any digit >= 5 would carry past 9 once doubled.
  always_comb begin
    accAdj = accQ;
    for (int i = 0; i < 5; i++) begin
      if (accQ[4*i +: 4] >= 4'd5) begin
        accAdj[4*i +: 4] = accQ[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    stateD    = stateQ;
    shiftD    = shiftQ;
    accD      = accQ;
    cntD      = cntQ;
    doneD     = 1'b0;
    hundredsD = hundredsQ;
    tensD     = tensQ;
    onesD     = onesQ;
    overflowD = overflowQ;
    seg2D     = seg2Q;
    seg1D     = seg1Q;
    seg0D     = seg0Q;

    unique case (stateQ)
      StIdle: begin
        if (bus.load) begin
          shiftD = bus.value;
          accD   = '0;
          cntD   = 5'(WIDTH);
          stateD = StConv;
        end
      end
      StConv: begin
        {accD, shiftD} = {accAdj, shiftQ} << 1;
        cntD = cntQ - 5'd1;
        if (cntQ == 5'd1) begin
          stateD = StFinish;
        end
      end
      StFinish: begin
        onesD     = accQ[3:0];
        tensD     = accQ[7:4];
        hundredsD = accQ[11:8];
        overflowD = |accQ[19:12];
        if (overflowD) begin
          seg2D = SegDash;
          seg1D = SegDash;
          seg0D = SegDash;
        end else begin
          seg0D = segOf(onesD);
          seg1D = (BLANK_LEADING && hundredsD == 4'd0 && tensD == 4'd0) ? SegBlank
                                                                         : segOf(tensD);
          seg2D = (BLANK_LEADING && hundredsD == 4'd0) ? SegBlank : segOf(hundredsD);
        end
        doneD  = 1'b1;
        stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      stateQ    <= StIdle;
      shiftQ    <= '0;
      accQ      <= '0;
      cntQ      <= '0;
      doneQ     <= 1'b0;
      hundredsQ <= '0;
      tensQ     <= '0;
      onesQ     <= '0;
      overflowQ <= 1'b0;
      seg2Q     <= SegLeadReset;
      seg1Q     <= SegLeadReset;
      seg0Q     <= SegZero;
    end else begin
      stateQ    <= stateD;
      shiftQ    <= shiftD;
      accQ      <= accD;
      cntQ      <= cntD;
      doneQ     <= doneD;
      hundredsQ <= hundredsD;
      tensQ     <= tensD;
      onesQ     <= onesD;
      overflowQ <= overflowD;
      seg2Q     <= seg2D;
      seg1Q     <= seg1D;
      seg0Q     <= seg0D;
    end
  end

  assign bus.busy     = (stateQ != StIdle);
  assign bus.done     = doneQ;
  assign bus.hundreds = hundredsQ;
  assign bus.tens     = tensQ;
  assign bus.ones     = onesQ;
  assign bus.overflow = overflowQ;
  assign bus.seg2     = seg2Q;
  assign bus.seg1     = seg1Q;
  assign bus.seg0     = seg0Q;

endmodule

// File: tb/tb_bcd_display_stage.sv
// Directed, table-driven bench for bcd_display_stage (WIDTH=16, blanking on).
module tb_bcd_display_stage;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic n_reset = 1'b0;

  bcd_display_stage_if #(.WIDTH(W)) bus ();

  bcd_display_stage #(
    .WIDTH(W),
    .BLANK_LEADING(1'b1)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  h;
    logic [3:0]  t;
    logic [3:0]  o;
    logic        ovf;
    logic [6:0]  s2;
    logic [6:0]  s1;
    logic [6:0]  s0;
  } vecT;

  vecT vecs[9];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Issue one load, then wait (bounded) for done; lat = edges after load edge.
  task automatic runConv(input logic [15:0] v, output int lat);
    @(negedge clk);
    bus.value = v;
    bus.load  = 1'b1;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    check("busy_after_load", 32'(bus.busy), 32'd1);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic checkResult(input vecT e, input int lat);
    check("latency", 32'(lat), 32'd17);
    check("busy_at_done", 32'(bus.busy), 32'd0);
    check("hundreds", 32'(bus.hundreds), 32'(e.h));
    check("tens", 32'(bus.tens), 32'(e.t));
    check("ones", 32'(bus.ones), 32'(e.o));
    check("overflow", 32'(bus.overflow), 32'(e.ovf));
    check("seg2", 32'(bus.seg2), 32'(e.s2));
    check("seg1", 32'(bus.seg1), 32'(e.s1));
    check("seg0", 32'(bus.seg0), 32'(e.s0));
  endtask

  task automatic checkResetState(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
    check({tag, "_digits"}, 32'({bus.hundreds, bus.tens, bus.ones}), 32'd0);
    check({tag, "_seg2"}, 32'(bus.seg2), 32'b1111111);
    check({tag, "_seg1"}, 32'(bus.seg1), 32'b1111111);
    check({tag, "_seg0"}, 32'(bus.seg0), 32'b1000000);
  endtask

  initial begin
    int lat;
    int doneCount;
    int doneAt;

    vecs = '{
      '{16'd123,   4'd1, 4'd2, 4'd3, 1'b0, 7'b1111001, 7'b0100100, 7'b0110000},
      '{16'd999,   4'd9, 4'd9, 4'd9, 1'b0, 7'b0010000, 7'b0010000, 7'b0010000},
      '{16'd1000,  4'd0, 4'd0, 4'd0, 1'b1, 7'b0111111, 7'b0111111, 7'b0111111},
      '{16'd65535, 4'd5, 4'd3, 4'd5, 1'b1, 7'b0111111, 7'b0111111, 7'b0111111},
      '{16'd7,     4'd0, 4'd0, 4'd7, 1'b0, 7'b1111111, 7'b1111111, 7'b1111000},
      '{16'd40,    4'd0, 4'd4, 4'd0, 1'b0, 7'b1111111, 7'b0011001, 7'b1000000},
      '{16'd100,   4'd1, 4'd0, 4'd0, 1'b0, 7'b1111001, 7'b1000000, 7'b1000000},
      '{16'd456,   4'd4, 4'd5, 4'd6, 1'b0, 7'b0011001, 7'b0010010, 7'b0000010},
      '{16'd1,     4'd0, 4'd0, 4'd1, 1'b0, 7'b1111111, 7'b1111111, 7'b1111001}
    };

    bus.value = '0;
    bus.load  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    @(negedge clk);
    n_reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      runConv(vecs[i].value, lat);
      checkResult(vecs[i], lat);
      @(posedge clk);
      #1;
      check("done_one_pulse", 32'(bus.done), 32'd0);
      check("hold_seg0", 32'(bus.seg0), 32'(vecs[i].s0));
    end

    // Second load while busy must be dropped.
    @(negedge clk);
    bus.value = 16'd5;
    bus.load  = 1'b1;
    @(posedge clk);
    #1;
    bus.load  = 1'b0;
    doneCount = 0;
    doneAt    = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 5) begin
        bus.value = 16'd8;
        bus.load  = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.done) begin
        doneCount++;
        if (doneAt < 0) doneAt = n;
      end
    end
    bus.load = 1'b0;
    check("drop_done_count", 32'(doneCount), 32'd1);
    check("drop_latency", 32'(doneAt), 32'd17);
    check("drop_ones", 32'(bus.ones), 32'd5);
    check("drop_seg0", 32'(bus.seg0), 32'b0010010);

    // Asynchronous reset mid-conversion.
    @(negedge clk);
    bus.value = 16'd456;
    bus.load  = 1'b1;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    n_reset = 1'b0;
    #1;
    checkResetState("abort");
    @(posedge clk);
    #1;
    check("abort_hold_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    @(posedge clk);
    #1;
    check("release_idle", 32'(bus.busy), 32'd0);
    runConv(16'd456, lat);
    checkResult(vecs[7], lat);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
